mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-high reset).
REQ-002 req  in  1  start strobe for one access, sampled only in IDLE.
REQ-003 mem_write  in  1  store request; takes priority over mem_to_reg.
REQ-004 mem_to_reg  in  1  load request.
REQ-005 load_type  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5-7 illegal.
REQ-006 store_type  in  2  0=SB, 1=SH, 2=SW; 3 illegal.
REQ-007 addr  in  32  byte address; wdata  in  32  store data, using the low 8/16/32 bits.
REQ-008 busy  out  1  high whenever state != IDLE; used as the pipeline stall.
REQ-009 done  out  1  one-cycle completion pulse; rdata  out  32  extended load result; err  out  1  misaligned/illegal flag, valid with done.
REQ-010 mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  8  byte-wide memory request side.
REQ-011 mem_ack  in  1, mem_rdata  in  8  memory response; a byte transfer completes on a clk edge with mem_req=1 and mem_ack=1.

Function
REQ-012 FSM states: IDLE, ACCESS, DONE; all outputs derive from registers only.
REQ-013 IDLE with req=1 SHALL latch the operation, addr, wdata and type, clear the byte index, and go to ACCESS; if the request is misaligned, illegal, or has neither mem_write nor mem_to_reg, it SHALL go directly to DONE.
REQ-014 Byte count: 1 for SB/LB/LBU, 2 for SH/LH/LHU, 4 for SW/LW.
REQ-015 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> err=1 in DONE, no memory traffic, rdata unchanged.
REQ-016 Illegal load_type (5-7) or store_type (3) SHALL take the same path as REQ-015, with err=1.
REQ-017 Neither mem_write nor mem_to_reg -> DONE with err=0, no memory traffic, rdata unchanged.
REQ-018 ACCESS: mem_req=1, mem_addr=latched addr+index, mem_we=1 for stores, mem_wdata=wdata byte[index] (little-endian; byte 0 = bits 7:0).
REQ-019 Each acked edge SHALL increment the index; on a load it SHALL store mem_rdata into byte[index] of the assembly register.
REQ-020 The ack of the last byte SHALL move the FSM to DONE; with no ack, ACCESS holds indefinitely with stable outputs.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; req is ignored in DONE and ACCESS.
REQ-022 On load completion, rdata SHALL update on entering DONE: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW is unmodified; stores leave rdata unchanged.
REQ-023 Latency with ack every cycle: req edge k -> mem_req during cycles k+1..k+N -> done high in cycle k+N+1; busy covers cycles k+1..k+N+1.
REQ-024 Address arithmetic is 32-bit modulo; 0xFFFFFFFF+1 wraps to 0 (only reachable for aligned byte accesses, so no wrap occurs within one access).
REQ-025 mem_we=0 and mem_wdata=0 whenever mem_req=0.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force IDLE and drive busy, done, err, mem_req, mem_we to 0 and rdata, mem_addr, mem_wdata to 0.
REQ-027 Reset mid-ACCESS SHALL abandon the access: no done pulse, partial load bytes discarded, mem_req low in the same cycle.
REQ-028 After rst deasserts, the first edge with req=1 SHALL be accepted normally.

Verification
REQ-029 LB addr=0x13, mem_rdata=0x80, ack immediate -> one request to 0x13, done 2 cycles after req, rdata=0xFFFFFF80, err=0.
REQ-030 LW addr=0x100, bytes 0x78,0x56,0x34,0x12, ack delayed 2 cycles per byte -> addrs 0x100..0x103 in order, rdata=0x12345678.
REQ-031 SH addr=0x22, wdata=0xAABBCCDD -> writes 0xDD@0x22 and 0xCC@0x23 with mem_we=1, rdata unchanged.
REQ-032 LH addr=0x21 and SW addr=0x42 -> no mem_req, done next cycle, err=1; load_type=6 also gives err=1.
REQ-033 LHU addr=0x30, rdata bytes 0xFE,0xFF -> rdata=0x0000FFFE; LH same data -> 0xFFFFFFFE.
REQ-034 rst pulsed during byte 2 of LW -> mem_req and busy drop immediately, no done; a following SB completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: splits LB/LH/LW/SB/SH/SW into byte transfers on an 8-bit memory port
// and returns the sign/zero-extended load result with a one-cycle done pulse.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic [2:0]  load_type,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_store;
   logic [2:0]  r_load_type;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_idx;
   logic [2:0]  r_last_idx;
   logic [31:0] r_asm;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_is_store;
   logic        w_is_load;
   logic        w_bad;
   logic        w_skip;
   logic [2:0]  w_nbytes;
   logic        w_accept;
   logic        w_xfer;
   logic        w_last;
   logic [31:0] w_asm_next;
   logic [31:0] w_load_ext;
   logic [7:0]  w_wbytes [4];

   assign w_is_store = mem_write;
   assign w_is_load  = ~mem_write & mem_to_reg;

   // Request decode: byte count plus misaligned/illegal detection.
   always_comb begin
      w_nbytes = 3'd1;
      w_bad    = 1'b0;
      if (w_is_store) begin
         case (store_type)
            2'd0:    w_nbytes = 3'd1;
            2'd1:    begin w_nbytes = 3'd2; w_bad = addr[0];      end
            2'd2:    begin w_nbytes = 3'd4; w_bad = |addr[1:0];   end
            default: w_bad = 1'b1;
         endcase
      end else if (w_is_load) begin
         case (load_type)
            3'd0, 3'd1: w_nbytes = 3'd1;
            3'd2, 3'd3: begin w_nbytes = 3'd2; w_bad = addr[0];    end
            3'd4:       begin w_nbytes = 3'd4; w_bad = |addr[1:0]; end
            default:    w_bad = 1'b1;
         endcase
      end
   end

   assign w_skip   = w_bad | ~(w_is_store | w_is_load);
   assign w_accept = (r_state == S_IDLE) & req;
   assign w_xfer   = (r_state == S_ACCESS) & mem_ack;
   assign w_last   = (r_idx == r_last_idx);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bytes
         assign w_wbytes[gi]            = r_wdata[gi*8 +: 8];
         assign w_asm_next[gi*8 +: 8]   = (r_idx[1:0] == 2'(gi)) ? mem_rdata : r_asm[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      case (r_load_type)
         3'd0:    w_load_ext = {{24{w_asm_next[7]}}, w_asm_next[7:0]};
         3'd1:    w_load_ext = {24'd0, w_asm_next[7:0]};
         3'd2:    w_load_ext = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
         3'd3:    w_load_ext = {16'd0, w_asm_next[15:0]};
         default: w_load_ext = w_asm_next;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (req) w_state_next = w_skip ? S_DONE : S_ACCESS;
         S_ACCESS: if (mem_ack && w_last) w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_store     <= 1'b0;
         r_load_type <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_idx       <= 3'd0;
         r_last_idx  <= 3'd0;
         r_asm       <= 32'd0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_store     <= w_is_store;
            r_load_type <= load_type;
            r_addr      <= addr;
            r_wdata     <= wdata;
            r_idx       <= 3'd0;
            r_last_idx  <= w_nbytes - 3'd1;
            r_asm       <= 32'd0;
            r_err       <= w_bad;
         end
         if (w_xfer) begin
            r_idx <= r_idx + 3'd1;
            if (!r_store) begin
               r_asm <= w_asm_next;
               // Final load byte: publish the extended result as DONE is entered.
               if (w_last) r_rdata <= w_load_ext;
            end
         end
      end
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
      err       = (r_state == S_DONE) & r_err;
      mem_req   = (r_state == S_ACCESS);
      mem_we    = (r_state == S_ACCESS) & r_store;
      mem_addr  = 32'd0;
      mem_wdata = 8'd0;
      if (r_state == S_ACCESS) begin
         mem_addr = r_addr + {29'd0, r_idx};
         if (r_store) mem_wdata = w_wbytes[r_idx[1:0]];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// against a byte-level reference model with a latency-configurable memory responder.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, mem_write, mem_to_reg;
   logic [2:0]  load_type;
   logic [1:0]  store_type;
   logic [31:0] addr, wdata;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem_model [0:255];
   logic [31:0] log_addr [$];
   logic        log_we [$];
   logic [7:0]  log_wd [$];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          zero_bad = 0;
   logic [31:0] model_rdata = 32'd0;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .req(req), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_model[mem_addr[7:0]];

   // Memory responder: acks each byte after ack_delay idle cycles.
   always @(negedge clk) begin
      if (mem_req !== 1'b1) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
         mem_ack  = 1'b1;
         wait_cnt = 0;
      end else begin
         mem_ack  = 1'b0;
         wait_cnt++;
      end
      if (mem_req !== 1'b1 && (mem_we !== 1'b0 || mem_wdata !== 8'd0)) zero_bad++;
   end

   always @(posedge clk) begin
      if (rst === 1'b0 && mem_req === 1'b1 && mem_ack === 1'b1) begin
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_wd.push_back(mem_wdata);
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_wd.delete();
   endtask

   // Drives one request and observes latency, err, rdata and busy/done behaviour.
   task automatic issue(input logic we, input logic m2r, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] rd,
                        output int bb, output logic dtwice);
      clear_log();
      @(negedge clk);
      req = 1'b1; mem_write = we; mem_to_reg = m2r; load_type = lt; store_type = st;
      addr = a; wdata = wd;
      @(negedge clk);
      req = 1'b0; addr = $urandom; wdata = $urandom;
      mem_write = 1'($urandom); mem_to_reg = 1'($urandom);
      lat = 1; bb = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) bb++;
         req = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b1) bb++;
      e = err; rd = rdata; req = 1'b0;
      @(negedge clk);
      dtwice = (done === 1'b1);
      $display("txn we=%0b m2r=%0b lt=%0d st=%0d addr=%h wdata=%h lat=%0d err=%0b rdata=%h xfers=%0d",
               we, m2r, lt, st, a, wd, lat, e, rd, log_addr.size());
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, err, mem_req, mem_we});
      end
      checks++;
      if (rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
         errors++; $display("FAIL reset_data got rdata=%h mem_addr=%h mem_wdata=%h want 0", rdata, mem_addr, mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_lb();
      int lat, bb; logic e, dt; logic [31:0] rd;
      mem_model[8'h13] = 8'h80; ack_delay = 0;
      issue(1'b0, 1'b1, 3'd0, 2'd0, 32'h13, 32'h0, lat, e, rd, bb, dt);
      checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency got %0d want 2", lat); end
      checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL lb_err got %b want 0", e); end
      checks++;
      if (log_addr.size() != 1 || log_addr[0] !== 32'h13 || log_we[0] !== 1'b0) begin
         errors++; $display("FAIL lb_xfer got n=%0d want one read at 00000013", log_addr.size());
      end
      checks++; if (bb != 0 || dt) begin errors++; $display("FAIL lb_busy_done got busy_gaps=%0d done_twice=%0b want 0 0", bb, dt); end
   endtask

   task automatic test_lw_delayed();
      int lat, bb; logic e, dt; logic [31:0] rd;
      mem_model[8'h00] = 8'h78; mem_model[8'h01] = 8'h56;
      mem_model[8'h02] = 8'h34; mem_model[8'h03] = 8'h12;
      ack_delay = 2;
      issue(1'b0, 1'b1, 3'd4, 2'd0, 32'h100, 32'h0, lat, e, rd, bb, dt);
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL lw_rdata got %h want 12345678", rd); end
      checks++; if (lat !== 13) begin errors++; $display("FAIL lw_latency got %0d want 13", lat); end
      checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL lw_count got %0d want 4", log_addr.size()); end
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         checks++;
         if (log_addr[i] !== 32'h100 + 32'(i) || log_we[i] !== 1'b0) begin
            errors++; $display("FAIL lw_addr%0d got %h we=%b want %h we=0", i, log_addr[i], log_we[i], 32'h100 + 32'(i));
         end
      end
      checks++; if (bb != 0 || dt) begin errors++; $display("FAIL lw_busy_done got busy_gaps=%0d done_twice=%0b want 0 0", bb, dt); end
   endtask

   task automatic test_sh();
      int lat, bb; logic e, dt; logic [31:0] rd;
      ack_delay = 1;
      issue(1'b1, 1'b0, 3'd0, 2'd1, 32'h22, 32'hAABBCCDD, lat, e, rd, bb, dt);
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL sh_rdata got %h want 12345678", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL sh_err got %b want 0", e); end
      checks++;
      if (log_addr.size() != 2) begin
         errors++; $display("FAIL sh_count got %0d want 2", log_addr.size());
      end else if (log_addr[0] !== 32'h22 || log_wd[0] !== 8'hDD || log_we[0] !== 1'b1 ||
                   log_addr[1] !== 32'h23 || log_wd[1] !== 8'hCC || log_we[1] !== 1'b1) begin
         errors++; $display("FAIL sh_bytes got %h@%h %h@%h want dd@00000022 cc@00000023",
                            log_wd[0], log_addr[0], log_wd[1], log_addr[1]);
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL sh_latency got %0d want 5", lat); end
   endtask

   task automatic test_errors();
      int lat, bb; logic e, dt; logic [31:0] rd;
      logic we, m2r; logic [2:0] lt; logic [1:0] st; logic [31:0] a;
      logic exp_e; int exp_n;
      ack_delay = 0;
      for (int c = 0; c < 6; c++) begin
         we = 1'b0; m2r = 1'b1; lt = 3'd0; st = 2'd0; a = 32'h40; exp_e = 1'b1; exp_n = 0;
         case (c)
            0: begin lt = 3'd2; a = 32'h21; end
            1: begin we = 1'b1; st = 2'd2; a = 32'h42; end
            2: lt = 3'd6;
            3: begin we = 1'b1; st = 2'd3; end
            4: begin m2r = 1'b0; exp_e = 1'b0; end
            default: begin we = 1'b1; st = 2'd0; a = 32'h44; exp_e = 1'b0; exp_n = 1; end
         endcase
         issue(we, m2r, lt, st, a, 32'h77, lat, e, rd, bb, dt);
         checks++; if (e !== exp_e) begin errors++; $display("FAIL err_case%0d_err got %b want %b", c, e, exp_e); end
         checks++;
         if (lat !== exp_n + 1 || log_addr.size() != exp_n) begin
            errors++; $display("FAIL err_case%0d_traffic got lat=%0d n=%0d want lat=%0d n=%0d", c, lat, log_addr.size(), exp_n + 1, exp_n);
         end
         checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL err_case%0d_rdata got %h want 12345678", c, rd); end
         if (exp_n == 1 && log_addr.size() == 1) begin
            checks++;
            if (log_we[0] !== 1'b1 || log_wd[0] !== 8'h77) begin
               errors++; $display("FAIL store_priority got we=%b wd=%h want we=1 wd=77", log_we[0], log_wd[0]);
            end
         end
      end
   endtask

   task automatic test_lhu_lh();
      int lat, bb; logic e, dt; logic [31:0] rd;
      mem_model[8'h30] = 8'hFE; mem_model[8'h31] = 8'hFF; ack_delay = 0;
      issue(1'b0, 1'b1, 3'd3, 2'd0, 32'h30, 32'h0, lat, e, rd, bb, dt);
      checks++; if (rd !== 32'h0000FFFE) begin errors++; $display("FAIL lhu_rdata got %h want 0000fffe", rd); end
      issue(1'b0, 1'b1, 3'd2, 2'd0, 32'h30, 32'h0, lat, e, rd, bb, dt);
      checks++; if (rd !== 32'hFFFFFFFE) begin errors++; $display("FAIL lh_rdata got %h want fffffffe", rd); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL lh_latency got %0d want 3", lat); end
   endtask

   task automatic test_reset_mid();
      int w, lat, bb; logic e, dt, saw_done; logic [31:0] rd;
      ack_delay = 2;
      clear_log();
      @(negedge clk);
      req = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; load_type = 3'd4; addr = 32'h100;
      @(negedge clk);
      req = 1'b0;
      w = 0;
      while (log_addr.size() < 1 && w < 50) begin @(negedge clk); w++; end
      checks++; if (w >= 50) begin errors++; $display("FAIL rstmid_first_byte got timeout want ack"); end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL rstmid_async got mem_req=%b busy=%b done=%b want 0 0 0", mem_req, busy, done);
      end
      saw_done = 1'b0;
      repeat (2) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
      rst = 1'b0;
      repeat (3) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
      checks++; if (saw_done) begin errors++; $display("FAIL rstmid_no_done got done pulse want none"); end
      ack_delay = 0;
      issue(1'b1, 1'b0, 3'd0, 2'd0, 32'h55, 32'h0000005A, lat, e, rd, bb, dt);
      checks++;
      if (lat !== 2 || log_addr.size() != 1 || rd !== 32'd0) begin
         errors++; $display("FAIL rstmid_sb got lat=%0d n=%0d rdata=%h want lat=2 n=1 rdata=0", lat, log_addr.size(), rd);
      end else begin
         checks++;
         if (log_addr[0] !== 32'h55 || log_we[0] !== 1'b1 || log_wd[0] !== 8'h5A) begin
            errors++; $display("FAIL rstmid_sb_byte got %h@%h we=%b want 5a@00000055 we=1", log_wd[0], log_addr[0], log_we[0]);
         end
      end
   endtask

   task automatic test_random();
      int lat, bb, size, n, elat; logic e, dt, exp_e; logic [31:0] rd, a, wd, ai;
      logic we, m2r, is_st, is_ld; logic [2:0] lt; logic [1:0] st;
      longint v;
      for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
      model_rdata = 32'd0;
      for (int t = 0; t < 40; t++) begin
         we = 1'($urandom); m2r = 1'($urandom_range(0, 3) != 0);
         lt = 3'($urandom_range(0, 5)); st = 2'($urandom_range(0, 3));
         a = $urandom; if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         wd = $urandom; ack_delay = $urandom_range(0, 2);
         is_st = we; is_ld = !we && m2r;
         if (is_st) size = (st == 0) ? 1 : (st == 1) ? 2 : (st == 2) ? 4 : 0;
         else       size = (lt <= 1) ? 1 : (lt <= 3) ? 2 : (lt == 4) ? 4 : 0;
         if (!is_st && !is_ld)               begin exp_e = 1'b0; n = 0; end
         else if (size == 0 || a % size != 0) begin exp_e = 1'b1; n = 0; end
         else                                begin exp_e = 1'b0; n = size; end
         elat = (n == 0) ? 1 : n * (ack_delay + 1) + 1;
         if (is_ld && n > 0) begin
            v = 0;
            for (int i = 0; i < n; i++) begin ai = a + 32'(i); v += longint'(mem_model[ai[7:0]]) << (8 * i); end
            if ((lt == 0 || lt == 2) && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
            model_rdata = v[31:0];
         end
         issue(we, m2r, lt, st, a, wd, lat, e, rd, bb, dt);
         checks++; if (e !== exp_e) begin errors++; $display("FAIL rnd%0d_err got %b want %b", t, e, exp_e); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", t, lat, elat); end
         checks++; if (rd !== model_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", t, rd, model_rdata); end
         checks++; if (log_addr.size() != n) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, log_addr.size(), n); end
         for (int i = 0; i < n && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== a + 32'(i) || log_we[i] !== is_st || log_wd[i] !== (is_st ? 8'(wd >> (8 * i)) : 8'd0)) begin
               errors++; $display("FAIL rnd%0d_byte%0d got %h@%h we=%b want %h@%h we=%b", t, i, log_wd[i], log_addr[i], log_we[i],
                                  is_st ? 8'(wd >> (8 * i)) : 8'd0, a + 32'(i), is_st);
            end
         end
         checks++; if (bb != 0 || dt) begin errors++; $display("FAIL rnd%0d_busy_done got gaps=%0d twice=%0b want 0 0", t, bb, dt); end
      end
      checks++; if (zero_bad != 0) begin errors++; $display("FAIL idle_port_quiet got %0d violations want 0", zero_bad); end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      load_type = 3'd0; store_type = 2'd0; addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0;
      for (int i = 0; i < 256; i++) mem_model[i] = 8'd0;
      test_reset();
      test_lb();
      test_lw_delayed();
      test_sh();
      test_errors();
      test_lhu_lh();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
